// File: rtl/player_dram_bridge_pkg.sv
// Shared types and constants for the player record DRAM bridge.
// Contents: bridge FSM state enum, 96-bit DRAM word layout, default
// address map constants, AXI OKAY response code, record pack helper.
package player_dram_bridge_pkg;

  localparam logic [16:0] BASE_ADDR_DEF      = 17'h10000;
  localparam int unsigned REC_STRIDE_LG2_DEF = 4;
  localparam int unsigned DRAM_DW_DEF        = 96;
  localparam int unsigned INFO_W             = 89;
  localparam logic [1:0]  RESP_OKAY          = 2'b00;

  typedef enum logic [2:0] {
    B_IDLE,
    B_AR,
    B_R,
    B_AW,
    B_W,
    B_B,
    B_RSP
  } bridge_state_t;

  typedef struct packed {
    logic [6:0]        pad;
    logic [INFO_W-1:0] info;
  } dram_word_t;

  function automatic dram_word_t pack_rec(input logic [INFO_W-1:0] info);
    dram_word_t w;
    w.pad  = '0;
    w.info = info;
    return w;
  endfunction

endpackage

// File: rtl/player_dram_bridge_cache.sv
// One-entry player record cache: valid bit, 8-bit player tag, 89-bit record.
// Only instantiated when RECORD_CACHE_EN is defined.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset (invalidates)
//   lookup_tag            player number being looked up
//   hit, hit_info         combinational hit flag and stored record
//   fill, fill_tag/info   load entry and mark valid
//   inval                 clear valid bit (fill has priority)
module player_rec_cache
  import player_dram_bridge_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        lookup_tag,
  output logic              hit,
  output logic [INFO_W-1:0] hit_info,
  input  logic              fill,
  input  logic [7:0]        fill_tag,
  input  logic [INFO_W-1:0] fill_info,
  input  logic              inval
);

  logic              valid_q;
  logic [7:0]        tag_q;
  logic [INFO_W-1:0] data_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else if (fill) begin
      valid_q <= 1'b1;
      tag_q   <= fill_tag;
      data_q  <= fill_info;
    end else if (inval) begin
      valid_q <= 1'b0;
    end
  end

  assign hit      = valid_q && (tag_q == lookup_tag);
  assign hit_info = data_q;

endmodule

// File: rtl/player_dram_bridge.sv
// Bridge between the action engine and DRAM: runs one player-record read or
// write per transaction over AR/R/AW/W/B channels and packs the 89-bit record
// into a 96-bit DRAM word (upper 7 bits zero).
// Ports:
//   clk, rst_n                         clock, synchronous active-low reset
//   req_valid/req_ready/req_write      request handshake and direction
//   req_player, req_info               player number, record to write
//   rsp_valid, rsp_info, rsp_err       completion pulse, record, error flag
//   ar_*, r_*, aw_*, w_*, b_*          DRAM channels
// Optional: define RECORD_CACHE_EN for a one-entry write-through record cache.
module player_dram_bridge
  import player_dram_bridge_pkg::*;
#(
  parameter logic [16:0] BASE_ADDR      = BASE_ADDR_DEF,
  parameter int unsigned REC_STRIDE_LG2 = REC_STRIDE_LG2_DEF,
  parameter int unsigned DRAM_DW        = DRAM_DW_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_write,
  input  logic [7:0]         req_player,
  input  logic [INFO_W-1:0]  req_info,
  output logic               rsp_valid,
  output logic [INFO_W-1:0]  rsp_info,
  output logic               rsp_err,
  output logic               ar_valid,
  input  logic               ar_ready,
  output logic [16:0]        ar_addr,
  input  logic               r_valid,
  output logic               r_ready,
  input  logic [DRAM_DW-1:0] r_data,
  input  logic [1:0]         r_resp,
  output logic               aw_valid,
  input  logic               aw_ready,
  output logic [16:0]        aw_addr,
  output logic               w_valid,
  input  logic               w_ready,
  output logic [DRAM_DW-1:0] w_data,
  input  logic               b_valid,
  output logic               b_ready,
  input  logic [1:0]         b_resp
);

  bridge_state_t     state_q, state_d;
  logic [16:0]       addr_q;
  logic [INFO_W-1:0] info_q;
  logic [INFO_W-1:0] rsp_info_q;
  logic              rsp_err_q;
  logic [16:0]       req_addr;
  logic              cache_hit;
  logic              unused_pad;

  assign req_addr   = BASE_ADDR + (17'(req_player) << REC_STRIDE_LG2);
  assign unused_pad = ^r_data[DRAM_DW-1:INFO_W];

`ifdef RECORD_CACHE_EN
  logic [7:0]        player_q;
  logic [INFO_W-1:0] cache_info;
  logic              cache_fill;
  logic              cache_inval;

  assign cache_fill  = (state_q == B_R && r_valid && r_resp == RESP_OKAY) ||
                       (state_q == B_B && b_valid && b_resp == RESP_OKAY);
  assign cache_inval = (state_q == B_B && b_valid && b_resp != RESP_OKAY);

  player_rec_cache u_cache (
    .clk        (clk),
    .rst_n      (rst_n),
    .lookup_tag (req_player),
    .hit        (cache_hit),
    .hit_info   (cache_info),
    .fill       (cache_fill),
    .fill_tag   (player_q),
    .fill_info  ((state_q == B_R) ? r_data[INFO_W-1:0] : info_q),
    .inval      (cache_inval)
  );
`else
  assign cache_hit = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    ar_valid  = 1'b0;
    r_ready   = 1'b0;
    aw_valid  = 1'b0;
    w_valid   = 1'b0;
    b_ready   = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      B_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_write)      state_d = B_AW;
          else if (cache_hit) state_d = B_RSP;
          else                state_d = B_AR;
        end
      end
      B_AR: begin
        ar_valid = 1'b1;
        if (ar_ready) state_d = B_R;
      end
      B_R: begin
        r_ready = 1'b1;
        if (r_valid) state_d = B_RSP;
      end
      B_AW: begin
        aw_valid = 1'b1;
        if (aw_ready) state_d = B_W;
      end
      B_W: begin
        w_valid = 1'b1;
        if (w_ready) state_d = B_B;
      end
      B_B: begin
        b_ready = 1'b1;
        if (b_valid) state_d = B_RSP;
      end
      B_RSP: begin
        rsp_valid = 1'b1;
        state_d   = B_IDLE;
      end
      default: state_d = B_IDLE;
    endcase
  end

  // Response registers load on the edge entering B_RSP, so the previous
  // result stays visible until the new rsp_valid pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= B_IDLE;
      addr_q     <= '0;
      info_q     <= '0;
      rsp_info_q <= '0;
      rsp_err_q  <= 1'b0;
`ifdef RECORD_CACHE_EN
      player_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      if (state_q == B_IDLE && req_valid) begin
        addr_q <= req_addr;
        info_q <= req_info;
`ifdef RECORD_CACHE_EN
        player_q <= req_player;
        if (!req_write && cache_hit) begin
          rsp_info_q <= cache_info;
          rsp_err_q  <= 1'b0;
        end
`endif
      end
      if (state_q == B_R && r_valid) begin
        rsp_info_q <= r_data[INFO_W-1:0];
        rsp_err_q  <= (r_resp != RESP_OKAY);
      end
      if (state_q == B_B && b_valid) begin
        rsp_info_q <= info_q;
        rsp_err_q  <= (b_resp != RESP_OKAY);
      end
    end
  end

  assign ar_addr  = addr_q;
  assign aw_addr  = addr_q;
  assign w_data   = DRAM_DW'(pack_rec(info_q));
  assign rsp_info = rsp_info_q;
  assign rsp_err  = rsp_err_q;

endmodule

// File: tb/tb_player_dram_bridge.sv
// Directed self-checking bench for player_dram_bridge.
// The bench plays the DRAM: address/data readies are driven per test, and
// R/B responses arrive one cycle after the bridge raises r_ready/b_ready.
module tb_player_dram_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_write;
  logic [7:0]  req_player;
  logic [88:0] req_info;
  logic        rsp_valid, rsp_err;
  logic [88:0] rsp_info;
  logic        ar_valid, ar_ready;
  logic [16:0] ar_addr;
  logic        r_valid, r_ready;
  logic [95:0] r_data;
  logic [1:0]  r_resp;
  logic        aw_valid, aw_ready;
  logic [16:0] aw_addr;
  logic        w_valid, w_ready;
  logic [95:0] w_data;
  logic        b_valid, b_ready;
  logic [1:0]  b_resp;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int          lat;
  bit          watch_busy = 0;
  bit          busy_bad   = 0;

  always #5 clk = ~clk;

  player_dram_bridge dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_player(req_player), .req_info(req_info),
    .rsp_valid(rsp_valid), .rsp_info(rsp_info), .rsp_err(rsp_err),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_resp(r_resp),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_resp(b_resp)
  );

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (watch_busy && req_ready) busy_bad = 1;
  endtask

  task automatic issue(input logic wr, input logic [7:0] p, input logic [88:0] info);
    int n = 0;
    req_valid = 1; req_write = wr; req_player = p; req_info = info;
    while (!req_ready && n < 20) begin tick(); n++; end
    check("req_ready_idle", req_ready, 1);
    tick();
    lat = 1;
    req_valid = 0;
  endtask

  task automatic serve_read(input logic [95:0] word, input logic [1:0] resp,
                            input int ar_wait, input logic [16:0] exp_addr);
    int n = 0;
    bit stable = 1;
    while (!ar_valid && n < 20) begin tick(); lat++; n++; end
    check("ar_valid", ar_valid, 1);
    check("ar_addr", ar_addr, exp_addr);
    repeat (ar_wait) begin
      tick(); lat++;
      if (!ar_valid || ar_addr !== exp_addr) stable = 0;
    end
    if (ar_wait > 0) check("ar_stable", stable, 1);
    ar_ready = 1; tick(); lat++; ar_ready = 0;
    check("r_ready", {ar_valid, r_ready}, 2'b01);
    tick(); lat++;
    r_valid = 1; r_data = word; r_resp = resp;
    tick(); lat++;
    r_valid = 0; r_data = '0; r_resp = 2'b00;
  endtask

  task automatic serve_write(input logic [1:0] resp, input int aw_wait, input int w_wait,
                             input logic [16:0] exp_addr, input logic [95:0] exp_wdata);
    int n = 0;
    bit stable = 1;
    while (!aw_valid && n < 20) begin tick(); lat++; n++; end
    check("aw_valid", aw_valid, 1);
    check("aw_addr", aw_addr, exp_addr);
    check("w_before_aw", w_valid, 0);
    repeat (aw_wait) begin
      tick(); lat++;
      if (!aw_valid || aw_addr !== exp_addr || w_valid) stable = 0;
    end
    if (aw_wait > 0) check("aw_stable", stable, 1);
    aw_ready = 1; tick(); lat++; aw_ready = 0;
    check("w_after_aw", {aw_valid, w_valid}, 2'b01);
    check("w_data", w_data, exp_wdata);
    stable = 1;
    repeat (w_wait) begin
      tick(); lat++;
      if (!w_valid || w_data !== exp_wdata) stable = 0;
    end
    if (w_wait > 0) check("w_stable", stable, 1);
    w_ready = 1; tick(); lat++; w_ready = 0;
    check("b_ready", {w_valid, b_ready}, 2'b01);
    tick(); lat++;
    b_valid = 1; b_resp = resp;
    tick(); lat++;
    b_valid = 0; b_resp = 2'b00;
  endtask

  task automatic expect_rsp(input string pfx, input int exp_lat,
                            input logic [88:0] exp_info, input logic exp_err);
    check({pfx, "_rsp_valid"}, rsp_valid, 1);
    check({pfx, "_latency"}, lat, exp_lat);
    check({pfx, "_rsp_info"}, rsp_info, exp_info);
    check({pfx, "_rsp_err"}, rsp_err, exp_err);
    tick();
    check({pfx, "_single_pulse"}, {rsp_valid, req_ready}, 2'b01);
    check({pfx, "_info_hold"}, rsp_info, exp_info);
  endtask

  logic [88:0] rec_a, rec_b, rec_w;
  bit          bad;

  initial begin
    rec_a = {16'h0100, 16'h0020, 16'h0500, 16'h0030, 16'h0040, 4'd7, 5'd14};
    rec_b = {16'hBEEF, 16'h1234, 16'h0A0A, 16'h5555, 16'h00FF, 4'd3, 5'd31};
    rec_w = {16'h0777, 16'h0001, 16'hFFFF, 16'h8000, 16'h0002, 4'd15, 5'd1};
    rst_n = 0; req_valid = 0; req_write = 0; req_player = '0; req_info = '0;
    ar_ready = 0; r_valid = 0; r_data = '0; r_resp = 2'b00;
    aw_ready = 0; w_ready = 0; b_valid = 0; b_resp = 2'b00;
    tick(); tick();

    // Reset state
    check("rst_ready_valids", {req_ready, ar_valid, r_ready, aw_valid, w_valid, b_ready, rsp_valid}, 7'b1000000);
    check("rst_rsp_info", rsp_info, '0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_addr", {ar_addr, aw_addr}, '0);
    check("rst_w_data", w_data, '0);
    rst_n = 1;
    tick();

    // Zero-wait read of player 3
    issue(0, 8'd3, '0);
    serve_read({7'b0, rec_a}, 2'b00, 0, 17'h10030);
    expect_rsp("rd3", 4, rec_a, 0);

    // Zero-wait write of player 7
    issue(1, 8'd7, rec_b);
    serve_write(2'b00, 0, 0, 17'h10070, {7'b0, rec_b});
    expect_rsp("wr7", 5, rec_b, 0);

    // Write with backpressure to player 255
    issue(1, 8'd255, rec_w);
    serve_write(2'b00, 3, 2, 17'h10FF0, {7'b0, rec_w});
    expect_rsp("wr255", 10, rec_w, 0);

    // Error read (pad bits set, must be dropped), then clean write
    issue(0, 8'd0, '0);
    serve_read({7'h7F, rec_b}, 2'b10, 1, 17'h10000);
    expect_rsp("rd_err", 5, rec_b, 1);
    issue(1, 8'd2, rec_a);
    serve_write(2'b00, 0, 0, 17'h10020, {7'b0, rec_a});
    expect_rsp("wr_ok", 5, rec_a, 0);

    // Back-to-back reads with req_valid held high
    req_valid = 1; req_write = 0; req_player = 8'd1;
    check("b2b_ready0", req_ready, 1);
    tick(); lat = 1;
    req_player = 8'd2;
    watch_busy = 1; busy_bad = 0;
    serve_read({7'b0, rec_w}, 2'b00, 0, 17'h10010);
    watch_busy = 0;
    check("b2b_busy_ready_low", busy_bad, 0);
    check("b2b_first_rsp", {rsp_valid, req_ready}, 2'b10);
    check("b2b_first_info", rsp_info, rec_w);
    tick();
    check("b2b_accept_after_rsp", req_ready, 1);
    tick(); lat = 1;
    req_valid = 0;
    serve_read({7'b0, rec_a}, 2'b00, 0, 17'h10020);
    expect_rsp("b2b_second", 4, rec_a, 0);

    // Reset while in B_W; late b_valid must be ignored
    issue(1, 8'd9, rec_b);
    aw_ready = 1; tick(); aw_ready = 0;
    check("midrst_w_valid", w_valid, 1);
    rst_n = 0; tick(); rst_n = 1;
    check("midrst_state", {w_valid, req_ready, rsp_valid}, 3'b010);
    check("midrst_rsp_info", rsp_info, '0);
    b_valid = 1; b_resp = 2'b00;
    bad = 0;
    repeat (3) begin tick(); if (rsp_valid || b_ready || !req_ready) bad = 1; end
    b_valid = 0;
    check("midrst_late_b_ignored", bad, 0);

`ifdef RECORD_CACHE_EN
    // Miss then hit on player 5
    issue(0, 8'd5, '0);
    serve_read({7'b0, rec_a}, 2'b00, 0, 17'h10050);
    expect_rsp("c_miss", 4, rec_a, 0);
    issue(0, 8'd5, '0);
    check("c_hit_no_ar", ar_valid, 0);
    expect_rsp("c_hit", 1, rec_a, 0);
    // Write-through then hit returns written record
    issue(1, 8'd5, rec_w);
    serve_write(2'b00, 0, 0, 17'h10050, {7'b0, rec_w});
    expect_rsp("c_wr", 5, rec_w, 0);
    issue(0, 8'd5, '0);
    check("c_hit2_no_ar", ar_valid, 0);
    expect_rsp("c_hit2", 1, rec_w, 0);
`else
    // Repeated read of player 5 still goes to DRAM
    issue(0, 8'd5, '0);
    serve_read({7'b0, rec_a}, 2'b00, 0, 17'h10050);
    expect_rsp("nc_rd1", 4, rec_a, 0);
    issue(0, 8'd5, '0);
    check("nc_rd2_uses_dram", ar_valid, 1);
    serve_read({7'b0, rec_w}, 2'b00, 0, 17'h10050);
    expect_rsp("nc_rd2", 4, rec_w, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
